// File: rtl/bus_pkg.sv
// Shared definitions for the two-master / two-slave system bus: widths,
// address map and grant-state encoding.
package bus_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 32;

    // S0: 2K-word data memory; S1: 32-word DMAC register file.
    localparam logic [ADDR_W-1:0] S0_BASE = 16'h0000;
    localparam logic [ADDR_W-1:0] S0_MASK = 16'hF800;
    localparam logic [ADDR_W-1:0] S1_BASE = 16'h7000;
    localparam logic [ADDR_W-1:0] S1_MASK = 16'hFFE0;

    // Read-return select values, sampled as {s1_sel, s0_sel}.
    localparam logic [1:0] RSEL_NONE = 2'b00;
    localparam logic [1:0] RSEL_S0   = 2'b01;
    localparam logic [1:0] RSEL_S1   = 2'b10;

    typedef enum logic {
        M0_GRANT = 1'b0,
        M1_GRANT = 1'b1
    } grant_state_e;

endpackage

// File: rtl/bus_arbiter_2m2s_if.sv
// Bus signal bundle between the two masters, the arbiter and the two slaves.
interface bus_arbiter_2m2s_if #(
    parameter int unsigned ADDR_W = bus_pkg::ADDR_W,
    parameter int unsigned DATA_W = bus_pkg::DATA_W
);
    logic              m0_req;
    logic              m0_wr;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_dout;
    logic              m0_grant;
    logic              m1_req;
    logic              m1_wr;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_dout;
    logic              m1_grant;
    logic [DATA_W-1:0] m_din;
    logic              s0_sel;
    logic              s1_sel;
    logic [ADDR_W-1:0] s_addr;
    logic              s_wr;
    logic [DATA_W-1:0] s_din;
    logic [DATA_W-1:0] s0_dout;
    logic [DATA_W-1:0] s1_dout;

    // Everything around the arbiter: masters and slave devices.
    modport master (
        output m0_req, m0_wr, m0_addr, m0_dout,
        output m1_req, m1_wr, m1_addr, m1_dout,
        output s0_dout, s1_dout,
        input  m0_grant, m1_grant, m_din,
        input  s0_sel, s1_sel, s_addr, s_wr, s_din
    );

    // The arbiter itself.
    modport slave (
        input  m0_req, m0_wr, m0_addr, m0_dout,
        input  m1_req, m1_wr, m1_addr, m1_dout,
        input  s0_dout, s1_dout,
        output m0_grant, m1_grant, m_din,
        output s0_sel, s1_sel, s_addr, s_wr, s_din
    );

endinterface

// File: rtl/bus_addr_decoder.sv
// Combinational address decoder: maps the muxed bus address to slave selects.
module bus_addr_decoder
    import bus_pkg::*;
#(
    parameter logic [ADDR_W-1:0] S0_B = S0_BASE,
    parameter logic [ADDR_W-1:0] S0_M = S0_MASK,
    parameter logic [ADDR_W-1:0] S1_B = S1_BASE,
    parameter logic [ADDR_W-1:0] S1_M = S1_MASK
) (
    input  logic [ADDR_W-1:0] s_addr,
    output logic              s0_sel,
    output logic              s1_sel
);

    logic hit0;
    logic hit1;

    always_comb begin
        hit0   = ((s_addr & S0_M) == S0_B);
        hit1   = ((s_addr & S1_M) == S1_B);
        s0_sel = hit0;
        // Memory has priority should a misconfigured map ever overlap.
        s1_sel = hit1 & ~hit0;
    end

endmodule

// File: rtl/bus_arbiter_2m2s.sv
// Two-master, two-slave bus arbiter: non-preemptive grant FSM, address/data
// mux, slave decode and one-cycle pipelined read-data return.
module bus_arbiter_2m2s
    import bus_pkg::*;
(
    input  logic clk,
    input  logic reset,
    bus_arbiter_2m2s_if.slave bus
);

    grant_state_e      state_q, state_d;
    logic [1:0]        rsel_q;
    logic [ADDR_W-1:0] s_addr;
    logic              wr_mux;
    logic              s0_sel;
    logic              s1_sel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= M0_GRANT;
            rsel_q  <= RSEL_NONE;
        end else begin
            state_q <= state_d;
            rsel_q  <= {s1_sel, s0_sel};
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            M0_GRANT: if (!bus.m0_req && bus.m1_req) state_d = M1_GRANT;
            M1_GRANT: if (!bus.m1_req) state_d = M0_GRANT;
            default:  state_d = M0_GRANT;
        endcase
    end

    always_comb begin
        bus.m0_grant = (state_q == M0_GRANT);
        bus.m1_grant = (state_q == M1_GRANT);
        if (state_q == M1_GRANT) begin
            s_addr    = bus.m1_addr;
            wr_mux    = bus.m1_wr;
            bus.s_din = bus.m1_dout;
        end else begin
            s_addr    = bus.m0_addr;
            wr_mux    = bus.m0_wr;
            bus.s_din = bus.m0_dout;
        end
    end

    bus_addr_decoder u_dec (
        .s_addr (s_addr),
        .s0_sel (s0_sel),
        .s1_sel (s1_sel)
    );

    always_comb begin
        bus.s_addr = s_addr;
        bus.s0_sel = s0_sel;
        bus.s1_sel = s1_sel;
        // Writes to unmapped addresses are dropped.
        bus.s_wr   = wr_mux & (s0_sel | s1_sel);
        case (rsel_q)
            RSEL_S0: bus.m_din = bus.s0_dout;
            RSEL_S1: bus.m_din = bus.s1_dout;
            default: bus.m_din = '0;
        endcase
    end

endmodule
